// File: rtl/spi_pkg.sv
// Shared constants and divisor arithmetic for the SPI baud generator slice.
package spi_pkg;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    localparam int SPI_DIV_W = 12;

    typedef logic [SPI_DIV_W-1:0] spi_div_t;

    // The shift amount is widened to 4 bits so spr=7 yields a shift of 8.
    function automatic spi_div_t baud_div(input logic [2:0] sppr, input logic [2:0] spr);
        spi_div_t   w_base;
        logic [3:0] w_shift;
        w_base  = SPI_DIV_W'(sppr) + SPI_DIV_W'(1);
        w_shift = {1'b0, spr} + 4'd1;
        return w_base << w_shift;
    endfunction

endpackage

// File: rtl/spi_baud_divisor.sv
// Baud divisor arithmetic; SPI_BAUD_SHADOW_EN latches sppr/spr for the duration of a transfer.
module spi_baud_divisor
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [2:0]       i_sppr,
    input  logic [2:0]       i_spr,
    input  logic             i_ss,
    output logic [DIV_W-1:0] o_divisor
);

    logic [2:0] w_selSppr;
    logic [2:0] w_selSpr;

`ifdef SPI_BAUD_SHADOW_EN
    logic [2:0] r_shadowSppr;
    logic [2:0] r_shadowSpr;
    logic       r_shadowValid;

    // Capture on the first cycle with ss low; release once ss rises.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_shadowSppr  <= 3'd0;
            r_shadowSpr   <= 3'd0;
            r_shadowValid <= 1'b0;
        end else if (i_ss) begin
            r_shadowValid <= 1'b0;
        end else if (!r_shadowValid) begin
            r_shadowSppr  <= i_sppr;
            r_shadowSpr   <= i_spr;
            r_shadowValid <= 1'b1;
        end
    end

    assign w_selSppr = r_shadowValid ? r_shadowSppr : i_sppr;
    assign w_selSpr  = r_shadowValid ? r_shadowSpr  : i_spr;
`else
    logic w_unused;

    assign w_unused  = &{1'b0, PCLK, PRESETn, i_ss};
    assign w_selSppr = i_sppr;
    assign w_selSpr  = i_spr;
`endif

    assign o_divisor = DIV_W'(baud_div(w_selSppr, w_selSpr));

endmodule

// File: rtl/spi_baud_generator.sv
// SCLK generator with per-edge sample/shift strobes. Optional build macro: SPI_BAUD_SHADOW_EN.
module spi_baud_generator
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    input  logic             ss,
    output logic [DIV_W-1:0] BaudRateDivisor,
    output logic             sclk,
    output logic             sample_stb,
    output logic             shift_stb
);

    logic [DIV_W-1:0] r_count;
    logic             r_sclk;
    logic             r_sampleStb;
    logic             r_shiftStb;

    logic [DIV_W-1:0] w_divisor;
    logic             w_active;
    logic             w_halfDone;
    logic             w_sampleEdge;

    spi_baud_divisor #(
        .DIV_W     (DIV_W)
    ) u_divisor (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_sppr    (sppr),
        .i_spr     (spr),
        .i_ss      (ss),
        .o_divisor (w_divisor)
    );

    assign w_active = ~ss & ((spi_mode == SPI_RUN) | ((spi_mode == SPI_WAIT) & ~spiswai));

    // >= rather than == so a live divisor shrinking mid-count cannot strand the counter.
    assign w_halfDone   = (r_count >= (w_divisor - DIV_W'(1)));
    assign w_sampleEdge = (r_sclk == cpol) ^ cpha;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_count     <= '0;
            r_sclk      <= 1'b0;
            r_sampleStb <= 1'b0;
            r_shiftStb  <= 1'b0;
        end else if (!w_active) begin
            r_count     <= '0;
            r_sclk      <= cpol;
            r_sampleStb <= 1'b0;
            r_shiftStb  <= 1'b0;
        end else if (w_halfDone) begin
            r_count     <= '0;
            r_sclk      <= ~r_sclk;
            r_sampleStb <= w_sampleEdge;
            r_shiftStb  <= ~w_sampleEdge;
        end else begin
            r_count     <= r_count + DIV_W'(1);
            r_sampleStb <= 1'b0;
            r_shiftStb  <= 1'b0;
        end
    end

    assign BaudRateDivisor = w_divisor;
    assign sclk            = r_sclk;
    assign sample_stb      = r_sampleStb;
    assign shift_stb       = r_shiftStb;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Scoreboard bench for spi_baud_generator; expected SCLK edges are queued per transfer and popped cycle by cycle.
module tb_spi_baud_generator;
    import spi_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic        cpol;
    logic        cpha;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic        ss;
    logic [11:0] BaudRateDivisor;
    logic        sclk;
    logic        sample_stb;
    logic        shift_stb;

    typedef struct {
        int   cyc;
        logic sclk;
        logic smp;
        logic shf;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    spi_baud_generator dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .spi_mode        (spi_mode),
        .spiswai         (spiswai),
        .cpol            (cpol),
        .cpha            (cpha),
        .sppr            (sppr),
        .spr             (spr),
        .ss              (ss),
        .BaudRateDivisor (BaudRateDivisor),
        .sclk            (sclk),
        .sample_stb      (sample_stb),
        .shift_stb       (shift_stb)
    );

    always #5 PCLK = ~PCLK;

    // Edge k of a transfer: odd k is the leading edge, which leaves sclk at ~cpol.
    task automatic addEdge(input int cyc, input int k, input logic pol, input logic pha);
        ev_t  e;
        logic leading;
        leading = (k % 2) == 1;
        e.cyc   = cyc;
        e.sclk  = leading ? ~pol : pol;
        e.smp   = leading ^ pha;
        e.shf   = ~(leading ^ pha);
        sb.push_back(e);
    endtask

    task automatic pushEdges(input int d, input int n, input logic pol, input logic pha);
        for (int k = 1; k * d <= n; k++) addEdge(k * d, k, pol, pha);
    endtask

    task automatic test_reset();
        ev_t  e;
        logic expS, expSmp, expShf;
        #1;
        total++;
        if ({sclk, sample_stb, shift_stb} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_poweron: got %b exp 000", {sclk, sample_stb, shift_stb});
        end
        @(negedge PCLK);
        PRESETn = 1'b1; sppr = 3'd1; spr = 3'd0; ss = 1'b0;
        repeat (4) begin @(posedge PCLK); @(negedge PCLK); end
        total++;
        if ({sclk, sample_stb, shift_stb} !== 3'b110) begin
            bad++; $display("[TB] FAIL reset_preedge: got %b exp 110", {sclk, sample_stb, shift_stb});
        end
        #2 PRESETn = 1'b0;
        #1;
        total++;
        if ({sclk, sample_stb, shift_stb} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_async: got %b exp 000", {sclk, sample_stb, shift_stb});
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        pushEdges(4, 8, 1'b0, 1'b0);
        expS = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL reset_restart t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
        end
        ss = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_basic();
        ev_t  e;
        logic expS, expSmp, expShf;
        sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0;
        #1;
        total++;
        if (BaudRateDivisor !== 12'd2) begin
            bad++; $display("[TB] FAIL basic_div: got %0d exp 2", BaudRateDivisor);
        end
        ss = 1'b0;
        pushEdges(2, 32, 1'b0, 1'b0);
        expS = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL basic t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("[TB] FAIL basic_edges: got %0d left exp 0", sb.size());
        end
        ss = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_divisor_range();
        ev_t  e;
        logic expS, expSmp, expShf;
        sppr = 3'd7; spr = 3'd7;
        #1;
        total++;
        if (BaudRateDivisor !== 12'd2048) begin
            bad++; $display("[TB] FAIL div_max: got %0d exp 2048", BaudRateDivisor);
        end
        sppr = 3'd2; spr = 3'd1;
        #1;
        total++;
        if (BaudRateDivisor !== 12'd12) begin
            bad++; $display("[TB] FAIL div_12: got %0d exp 12", BaudRateDivisor);
        end
        @(negedge PCLK);
        ss = 1'b0;
        pushEdges(12, 24, 1'b0, 1'b0);
        expS = 1'b0;
        for (int t = 1; t <= 24; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL div12 t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
        end
        ss = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_cpol_cpha();
        ev_t  e;
        logic expS, expSmp, expShf;
        cpol = 1'b1; cpha = 1'b1; sppr = 3'd1; spr = 3'd0;
        @(negedge PCLK);
        total++;
        if (sclk !== 1'b1) begin
            bad++; $display("[TB] FAIL cpol_idle: got %b exp 1", sclk);
        end
        ss = 1'b0;
        pushEdges(4, 16, 1'b1, 1'b1);
        expS = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL mode3 t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
        end
        ss = 1'b1;
        @(negedge PCLK);
        cpol = 1'b0; cpha = 1'b0;
        @(negedge PCLK);
        total++;
        if (sclk !== 1'b0) begin
            bad++; $display("[TB] FAIL cpol_follow: got %b exp 0", sclk);
        end
    endtask

    task automatic test_wait_stop();
        ev_t  e;
        logic expS, expSmp, expShf;
        spi_mode = SPI_WAIT; spiswai = 1'b0; sppr = 3'd1; spr = 3'd0; ss = 1'b0;
        pushEdges(4, 6, 1'b0, 1'b0);
        expS = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL wait_run t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
        end
        spiswai = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            total++;
            if ({sclk, sample_stb, shift_stb} !== 3'b000) begin
                bad++; $display("[TB] FAIL wait_stopped t=%0d: got %b exp 000", t, {sclk, sample_stb, shift_stb});
            end
        end
        spiswai = 1'b0;
        pushEdges(4, 8, 1'b0, 1'b0);
        expS = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL wait_resume t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
        end
        spi_mode = SPI_STOP;
        for (int t = 1; t <= 6; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            total++;
            if ({sclk, sample_stb, shift_stb} !== 3'b000) begin
                bad++; $display("[TB] FAIL stop_mode t=%0d: got %b exp 000", t, {sclk, sample_stb, shift_stb});
            end
        end
        ss = 1'b1; spi_mode = SPI_RUN;
        @(negedge PCLK);
    endtask

    task automatic test_shadow();
        ev_t  e;
        logic expS, expSmp, expShf;
        logic [11:0] expDiv;
        sppr = 3'd0; spr = 3'd0; ss = 1'b0;
`ifdef SPI_BAUD_SHADOW_EN
        pushEdges(2, 22, 1'b0, 1'b0);
        expDiv = 12'd2;
`else
        addEdge(2, 1, 1'b0, 1'b0);
        addEdge(4, 2, 1'b0, 1'b0);
        addEdge(20, 3, 1'b0, 1'b0);
        expDiv = 12'd16;
`endif
        expS = 1'b0;
        for (int t = 1; t <= 22; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL shadow t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
            if (t == 5) spr = 3'd3;
            if (t == 6) begin
                total++;
                if (BaudRateDivisor !== expDiv) begin
                    bad++; $display("[TB] FAIL shadow_div: got %0d exp %0d", BaudRateDivisor, expDiv);
                end
            end
        end
        ss = 1'b1;
        @(negedge PCLK);
        total++;
        if ({sclk, sample_stb, shift_stb, BaudRateDivisor} !== {3'b000, 12'd16}) begin
            bad++; $display("[TB] FAIL shadow_release: got %b/%0d exp 000/16", {sclk, sample_stb, shift_stb}, BaudRateDivisor);
        end
        ss = 1'b0;
        pushEdges(16, 32, 1'b0, 1'b0);
        expS = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (sb.size() > 0 && sb[0].cyc == t) begin
                e = sb.pop_front(); expS = e.sclk; expSmp = e.smp; expShf = e.shf;
            end else begin
                expSmp = 1'b0; expShf = 1'b0;
            end
            total++;
            if ({sclk, sample_stb, shift_stb} !== {expS, expSmp, expShf}) begin
                bad++; $display("[TB] FAIL shadow_next t=%0d: got %b exp %b", t, {sclk, sample_stb, shift_stb}, {expS, expSmp, expShf});
            end
        end
        ss = 1'b1;
        @(negedge PCLK);
    endtask

    initial begin
        PRESETn = 1'b0; spi_mode = SPI_RUN; spiswai = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sppr = 3'd0; spr = 3'd0; ss = 1'b1;
        #12;
        test_reset();
        test_basic();
        test_divisor_range();
        test_cpol_cpha();
        test_wait_stop();
        test_shadow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
